// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and state type for the multicycle RISC-V main control.
// ILLEGAL_TRAP_EN adds the TRAP state to the state enum.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXECUTE,
        R_WB,
        BRANCH
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Controller <-> datapath bundle: instruction/handshake inputs and control outputs.
interface multicycle_main_control_if;

    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       reg_write;
    logic       mem_to_reg;

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_write_cond, pc_source, reg_write, mem_to_reg
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_write_cond, pc_source, reg_write, mem_to_reg
    );

endinterface

// File: rtl/multicycle_next_state.sv
// Combinational next-state function of the main control FSM.
// With ILLEGAL_TRAP_EN an unknown opcode in DECODE goes to TRAP, else back to FETCH.
module multicycle_next_state
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output state_t     next_state
);

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:     next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LD, OP_SD: next_state = MEM_ADDR;
                    OP_R:         next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:      next_state = TRAP;
`else
                    default:      next_state = FETCH;
`endif
                endcase
            end
            // Only ld/sd reach MEM_ADDR, and the IR holds the opcode stable.
            MEM_ADDR:  next_state = (opcode == OP_LD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   next_state = R_WB;
            R_WB:      next_state = FETCH;
            BRANCH:    next_state = FETCH;
`ifdef ILLEGAL_TRAP_EN
            TRAP:      next_state = TRAP;
`endif
            default:   next_state = FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control of the multicycle RISC-V core: state register, output decode,
// retired-instruction counter and sticky illegal flag (ILLEGAL_TRAP_EN enables the trap).
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
)
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_main_control_if.master ctrl,
    output logic                     illegal_instr,
    output logic [CNT_W-1:0]         instr_count
);

    state_t state;
    state_t next_state;
    logic   retire;

    multicycle_next_state u_next_state (
        .state      (state),
        .opcode     (ctrl.opcode),
        .mem_ready  (ctrl.mem_ready),
        .next_state (next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        ctrl.alu_op        = ALU_OP_ADD;
        ctrl.alu_src_a     = 1'b0;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.iord          = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.ir_write      = 1'b0;
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.pc_source     = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRC_B_FOUR;
                    ctrl.ir_write  = ctrl.mem_ready;
                    ctrl.pc_write  = ctrl.mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_b = SRC_B_IMM;
                end
                MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_IMM;
                end
                MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALU_OP_FUNCT;
                end
                R_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALU_OP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        retire = (state == MEM_WB) || (state == R_WB) || (state == BRANCH) ||
                 ((state == MEM_WRITE) && ctrl.mem_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Registered on the DECODE->TRAP transition so the flag is high for every TRAP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_instr <= 1'b0;
        end else if (next_state == TRAP) begin
            illegal_instr <= 1'b1;
        end
    end
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
